// File: rtl/cpu_bus_port.sv
// cpu_bus_port: latches one CPU request and runs it as a single strobed W_* bus transfer; optional bus timeout under `BUS_TIMEOUT_EN.
// Latency: strobe one cycle after req_en is sampled; rsp_ack one cycle after W_ACK (minimum 2 cycles from request, 3-cycle repeat).
// Backpressure: the CPU holds req_en until rsp_ack; the bus stalls the port by withholding W_ACK (bounded only with the timeout).
module cpu_bus_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        W_RST,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_thread,
    output logic [31:0] rsp_rdata,
    output logic        rsp_ack,
    output logic        rsp_err,
    output logic [31:0] W_ADDR,
    output logic [31:0] W_DATA_O,
    output logic        W_WRITE,
    output logic        W_STB,
    output logic [1:0]  W_TID,
    input  logic [31:0] W_DATA_I,
    input  logic        W_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  tid_q, tid_d;
    logic        write_q, write_d;
    logic        stb_q, stb_d;
    logic        ack_q, ack_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tid_d   = tid_q;
        write_d = write_q;
        stb_d   = stb_q;
        ack_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_en) begin
                    state_d = BUS;
                    stb_d   = 1'b1;
                    write_d = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    tid_d   = req_thread;
`ifdef BUS_TIMEOUT_EN
                    wait_cnt_d = 16'd0;
`endif
                end
            end
            BUS: begin
                // An ack on the timeout edge still completes normally.
                if (W_ACK) begin
                    state_d = RESP;
                    rdata_d = write_q ? 32'h0 : W_DATA_I;
                    ack_d   = 1'b1;
                    stb_d   = 1'b0;
                    write_d = 1'b0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LIM) begin
                    state_d = RESP;
                    rdata_d = 32'hFFFF_FFFF;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    stb_d   = 1'b0;
                    write_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                // req_en deliberately not looked at here, so dropping it on ack is safe.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (W_RST) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            tid_q   <= 2'd0;
            write_q <= 1'b0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tid_q   <= tid_d;
            write_q <= write_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (W_RST) begin
            wait_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_rdata = rdata_q;
    assign rsp_ack   = ack_q;
    assign W_ADDR    = addr_q;
    assign W_DATA_O  = wdata_q;
    assign W_WRITE   = write_q;
    assign W_STB     = stb_q;
    assign W_TID     = tid_q;

endmodule

// File: tb/tb_cpu_bus_port.sv
// Bench for cpu_bus_port: directed transfers, scoreboard of expected responses popped by an ack monitor.
module tb_cpu_bus_port;

    logic        clk = 1'b0;
    logic        W_RST;
    logic        req_en;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_thread;
    logic [31:0] rsp_rdata;
    logic        rsp_ack;
    logic        rsp_err;
    logic [31:0] W_ADDR;
    logic [31:0] W_DATA_O;
    logic        W_WRITE;
    logic        W_STB;
    logic [1:0]  W_TID;
    logic [31:0] W_DATA_I;
    logic        W_ACK;

    always #5 clk = ~clk;

    cpu_bus_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .W_RST      (W_RST),
        .req_en     (req_en),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_thread (req_thread),
        .rsp_rdata  (rsp_rdata),
        .rsp_ack    (rsp_ack),
        .rsp_err    (rsp_err),
        .W_ADDR     (W_ADDR),
        .W_DATA_O   (W_DATA_O),
        .W_WRITE    (W_WRITE),
        .W_STB      (W_STB),
        .W_TID      (W_TID),
        .W_DATA_I   (W_DATA_I),
        .W_ACK      (W_ACK)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ack_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every ack consumes one expected response.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_ack === 1'b1) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual rdata=%h err=%b required=no_ack", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One transfer: request, `waits` cycles with W_ACK low, then W_ACK with bus_rdata.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] tid, input int waits, input logic [31:0] bus_rdata,
                        input logic hold_en, input logic [31:0] alt_addr);
        rsp_t e;
        e.rdata = we ? 32'h0 : bus_rdata;
        e.err   = 1'b0;
        exp_q.push_back(e);
        req_en     = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_thread = tid;
        step;
        req_addr = alt_addr;
        chk("stb_first", 32'(W_STB), 32'd1);
        chk("write_first", 32'(W_WRITE), 32'(we));
        chk("addr_first", W_ADDR, addr);
        chk("wdata_out", W_DATA_O, wdata);
        chk("tid_out", 32'(W_TID), 32'(tid));
        for (int i = 0; i < waits; i++) begin
            step;
            chk("stb_wait", 32'(W_STB), 32'd1);
            chk("write_wait", 32'(W_WRITE), 32'(we));
            chk("addr_wait", W_ADDR, addr);
            chk("ack_wait", 32'(rsp_ack), 32'd0);
        end
        W_ACK    = 1'b1;
        W_DATA_I = bus_rdata;
        step;
        W_ACK    = 1'b0;
        W_DATA_I = 32'h0;
        if (!hold_en) req_en = 1'b0;
        chk("ack_high", 32'(rsp_ack), 32'd1);
        chk("stb_after_ack", 32'(W_STB), 32'd0);
        chk("write_after_ack", 32'(W_WRITE), 32'd0);
        step;
        req_addr = addr;
        chk("ack_one_cycle", 32'(rsp_ack), 32'd0);
        chk("rdata_hold", rsp_rdata, e.rdata);
        chk("stb_idle", 32'(W_STB), 32'd0);
        chk("addr_hold", W_ADDR, addr);
    endtask

    initial begin : stim
        int a0;
        int lat;
        W_RST      = 1'b1;
        req_en     = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_thread = 2'd0;
        W_DATA_I   = 32'h0;
        W_ACK      = 1'b0;
        step;
        step;
        W_RST = 1'b0;

        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_ack", 32'(rsp_ack), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_addr", W_ADDR, 32'h0);
        chk("rst_wdata", W_DATA_O, 32'h0);
        chk("rst_write", 32'(W_WRITE), 32'd0);
        chk("rst_stb", 32'(W_STB), 32'd0);
        chk("rst_tid", 32'(W_TID), 32'd0);

        // Zero-wait read.
        xfer(1'b0, 32'h10, 32'h0, 2'd1, 0, 32'h1234_5678, 1'b0, 32'h10);
        // Write with 3 waits; req_addr moved to 0x99 during BUS; bus read data must be ignored.
        xfer(1'b1, 32'h20, 32'hCAFE_F00D, 2'd2, 3, 32'hDEAD_BEEF, 1'b0, 32'h99);

        // Enable held across RESP: one IDLE cycle, then a second transfer.
        xfer(1'b0, 32'h30, 32'h0, 2'd3, 1, 32'hAAAA_5555, 1'b1, 32'h30);
        xfer(1'b0, 32'h30, 32'h0, 2'd3, 0, 32'h5555_AAAA, 1'b0, 32'h30);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("no_restrobe", 32'(W_STB), 32'd0);
        end

        // Ack on the same edge the timeout would fire (4 waits with limit 4) completes normally.
        xfer(1'b0, 32'h50, 32'h0, 2'd0, 4, 32'h0BAD_CAFE, 1'b0, 32'h50);

        // Reset mid-transfer.
        a0         = ack_seen;
        req_en     = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h60;
        req_wdata  = 32'h1111_2222;
        req_thread = 2'd2;
        step;
        chk("rst_mid_stb_before", 32'(W_STB), 32'd1);
        req_en = 1'b0;
        W_RST  = 1'b1;
        step;
        W_RST = 1'b0;
        chk("rst_mid_stb", 32'(W_STB), 32'd0);
        chk("rst_mid_write", 32'(W_WRITE), 32'd0);
        chk("rst_mid_addr", W_ADDR, 32'h0);
        chk("rst_mid_wdata", W_DATA_O, 32'h0);
        chk("rst_mid_tid", 32'(W_TID), 32'd0);
        chk("rst_mid_rdata", rsp_rdata, 32'h0);
        W_ACK    = 1'b1;
        W_DATA_I = 32'h7777_7777;
        step;
        W_ACK    = 1'b0;
        W_DATA_I = 32'h0;
        step;
        step;
        chk("rst_mid_no_ack", 32'(ack_seen - a0), 32'd0);
        chk("rst_mid_stb_later", 32'(W_STB), 32'd0);

        // Bus never acknowledges.
        a0         = ack_seen;
        lat        = 0;
        req_en     = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h40;
        req_thread = 2'd1;
`ifdef BUS_TIMEOUT_EN
        exp_q.push_back(rsp_t'({32'hFFFF_FFFF, 1'b1}));
`endif
        for (int k = 1; k <= 100; k++) begin
            step;
            if (rsp_ack === 1'b1 && lat == 0) begin
                lat    = k;
                req_en = 1'b0;
            end
        end
`ifdef BUS_TIMEOUT_EN
        chk("timeout_acks", 32'(ack_seen - a0), 32'd1);
        chk("timeout_latency", 32'(lat), 32'd6);
        chk("timeout_stb_off", 32'(W_STB), 32'd0);
`else
        chk("no_timeout_acks", 32'(ack_seen - a0), 32'd0);
        chk("no_timeout_stb", 32'(W_STB), 32'd1);
        chk("no_timeout_err", 32'(rsp_err), 32'd0);
`endif
        req_en = 1'b0;
        W_RST  = 1'b1;
        step;
        W_RST = 1'b0;
        step;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
